// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and decode helpers for the multicycle RV32I control path.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrLink = 4'd12,
    StLui      = 4'd13,
    StAuipc    = 4'd14,
    StTrap     = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = ImmI;
    case (op)
      OpStore:        imm = ImmS;
      OpBranch:       imm = ImmB;
      OpLui, OpAuipc: imm = ImmU;
      OpJal:          imm = ImmJ;
      default:        imm = ImmI;
    endcase
    return imm;
  endfunction

  // funct3 010/011 are unused in the branch opcode space.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic state_e decode_next(input logic [6:0] op, input logic [2:0] f3);
    state_e nxt;
    nxt = StTrap;
    case (op)
      OpLoad, OpStore: nxt = StMemAdr;
      OpR:             nxt = StExecR;
      OpI:             nxt = StExecI;
      OpBranch:        nxt = branch_f3_legal(f3) ? StBranch : StTrap;
      OpJal:           nxt = StJal;
      OpJalr:          nxt = StJalr;
      OpLui:           nxt = StLui;
      OpAuipc:         nxt = StAuipc;
      default:         nxt = StTrap;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps {opcode, funct3, funct7b5} to the ALU operation for R- and I-type arithmetic.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o
);

  logic is_r;
  logic is_arith;

  assign is_r     = (opcode_i == OpR);
  assign is_arith = is_r || (opcode_i == OpI);

  always_comb begin
    alu_ctrl_o = AluAdd;
    if (is_arith) begin
      unique case (funct3_i)
        // Immediate forms have no SUB; bit 30 belongs to the immediate there.
        3'b000: alu_ctrl_o = (is_r && funct7b5_i) ? AluSub : AluAdd;
        3'b001: alu_ctrl_o = AluSll;
        3'b010: alu_ctrl_o = AluSlt;
        3'b011: alu_ctrl_o = AluSltu;
        3'b100: alu_ctrl_o = AluXor;
        3'b101: alu_ctrl_o = funct7b5_i ? AluSra : AluSrl;
        3'b110: alu_ctrl_o = AluOr;
        3'b111: alu_ctrl_o = AluAnd;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with req/ready memory handshake, optional timeout and trap state.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       ovf,
  input  logic       carry,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       trap,
  output logic [3:0] state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_alu;
  logic             br_taken;
  logic             timeout_hit;

  logic       mem_req_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c, mem_write_c;
  logic [1:0] src_a_c, src_b_c, res_src_c;
  logic [3:0] alu_ctrl_c;

  alu_decoder u_alu_decoder (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (dec_alu)
  );

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = neg ^ ovf;
      3'b101:  br_taken = !(neg ^ ovf);
      3'b110:  br_taken = !carry;
      3'b111:  br_taken = carry;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    adr_src_c   = 1'b0;
    src_a_c     = SrcAPc;
    src_b_c     = SrcBRs2;
    alu_ctrl_c  = AluAdd;
    res_src_c   = ResAluOut;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        src_b_c   = SrcBFour;
        res_src_c = ResAluResult;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        src_a_c = SrcAOldPc;
        src_b_c = SrcBImm;
        state_d = decode_next(opcode, funct3);
      end
      StMemAdr: begin
        src_a_c = SrcARs1;
        src_b_c = SrcBImm;
        state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        res_src_c   = ResData;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        src_a_c    = SrcARs1;
        src_b_c    = SrcBRs2;
        alu_ctrl_c = dec_alu;
        state_d    = StAluWb;
      end
      StExecI: begin
        src_a_c    = SrcARs1;
        src_b_c    = SrcBImm;
        alu_ctrl_c = dec_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        res_src_c   = ResAluOut;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        src_a_c    = SrcARs1;
        src_b_c    = SrcBRs2;
        alu_ctrl_c = AluSub;
        res_src_c  = ResAluOut;
        pc_write_c = br_taken;
        state_d    = StFetch;
      end
      StJal: begin
        src_a_c    = SrcAOldPc;
        src_b_c    = SrcBFour;
        res_src_c  = ResAluOut;
        pc_write_c = 1'b1;
        state_d    = StAluWb;
      end
      StJalr: begin
        src_a_c    = SrcARs1;
        src_b_c    = SrcBImm;
        res_src_c  = ResAluResult;
        pc_write_c = 1'b1;
        state_d    = StJalrLink;
      end
      StJalrLink: begin
        // Link value OldPC+4 lands in ALUOut for the following write-back.
        src_a_c = SrcAOldPc;
        src_b_c = SrcBFour;
        state_d = StAluWb;
      end
      StLui: begin
        src_a_c = SrcAZero;
        src_b_c = SrcBImm;
        state_d = StAluWb;
      end
      StAuipc: begin
        src_a_c = SrcAOldPc;
        src_b_c = SrcBImm;
        state_d = StAluWb;
      end
      StTrap: begin
        state_d = StTrap;
      end
    endcase

    // A ready arriving in the final allowed wait cycle still completes the access.
    timeout_hit = (MEM_TIMEOUT != 0) && mem_req_c && !mem_ready
                  && (cnt_q == CNT_W'(MEM_TIMEOUT));
    if (timeout_hit) state_d = StTrap;
  end

  always_comb begin
    cnt_d = '0;
    if ((MEM_TIMEOUT != 0) && mem_req_c && !mem_ready && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign mem_req    = reset & mem_req_c;
  assign AdrSrc     = reset & adr_src_c;
  assign ImmSrc     = reset ? imm_src_of(opcode) : 3'b000;
  assign ALUSrcA    = reset ? src_a_c : 2'b00;
  assign ALUSrcB    = reset ? src_b_c : 2'b00;
  assign ALUControl = reset ? alu_ctrl_c : 4'd0;
  assign ResultSrc  = reset ? res_src_c : 2'b00;
  assign IRWrite    = reset & ir_write_c;
  assign PCWrite    = reset & pc_write_c;
  assign RegWrite   = reset & reg_write_c;
  assign MemWrite   = reset & mem_write_c;
  assign trap       = reset & (state_q == StTrap);
  assign state_dbg  = reset ? state_q : 4'd0;

endmodule
